key_filter_multi: RTL and testbench

//  Multi-channel push-button debouncer, parametrised successor to the single-key 20 ms filter.

---
 rtl/key_filter_pkg.sv | 13 +
 rtl/key_filter_multi_if.sv | 29 ++
 rtl/key_filter_chan.sv | 121 ++++++++++++
 rtl/key_filter_multi.sv | 52 +++++
 tb/tb_key_filter_multi.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_filter_pkg.sv
// key_filter_pkg
// Shared constants for the key debouncer family. All timing values are in
// sys_clk cycles at SYS_CLK_HZ.
//   SYS_CLK_HZ        nominal system clock frequency (50 MHz)
//   KEY_CNT_MAX_20MS  debounce length for 20 ms (a change must persist this value + 1 cycles)
//   KEY_LONG_MAX_1S   hold length for a 1 s long press
package key_filter_pkg;

    localparam int SYS_CLK_HZ       = 50_000_000;
    localparam int KEY_CNT_MAX_20MS = 999_999;
    localparam int KEY_LONG_MAX_1S  = 49_999_999;

endpackage

// File: rtl/key_filter_multi_if.sv
// key_filter_multi_if
// Bundles the raw key pins and the debounced key outputs of key_filter_multi.
//   key_in       raw asynchronous key pins (driven by the board / master side)
//   key_state    debounced level per key, 1 = pressed
//   key_press    one-cycle pulse on released->pressed
//   key_release  one-cycle pulse on pressed->released
//   key_long     one-cycle pulse on long press (0 when long press is not built)
// Modports: master = pin driver / result consumer, slave = the debouncer.
interface key_filter_multi_if #(
    parameter int N_KEYS = 4
);

    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;

    modport master (
        output key_in,
        input  key_state, key_press, key_release, key_long
    );

    modport slave (
        input  key_in,
        output key_state, key_press, key_release, key_long
    );

endinterface

// File: rtl/key_filter_chan.sv
// key_filter_chan
// One debounced key channel: 2-flop synchroniser, bidirectional debounce
// counter, stable level and registered press/release pulses. Optional hold
// counter producing a one-shot long-press pulse when LONG_PRESS_EN is defined.
// Ports:
//   sys_clk      system clock
//   sys_rst      synchronous active-high reset
//   key_pin      raw asynchronous key pin
//   key_state    debounced level, 1 = pressed
//   key_press    one-cycle pulse, high the cycle key_state first shows 1
//   key_release  one-cycle pulse, high the cycle key_state first shows 0
//   key_long     one-cycle pulse after LONG_MAX cycles of stable press
// Build option: LONG_PRESS_EN (undefined -> key_long tied to 0).
module key_filter_chan
    import key_filter_pkg::*;
#(
    parameter int CNT_MAX        = KEY_CNT_MAX_20MS,
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int LONG_MAX       = KEY_LONG_MAX_1S
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_pin,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    logic             sync1_reg, sync2_reg;
    logic             raw_act;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             state_reg, state_next;
    logic             press_reg, press_next;
    logic             release_reg, release_next;

    // Normalise pin polarity so 1 always means "pressed".
    assign raw_act = sync2_reg ^ KEY_ACTIVE_LOW;

    // Counter runs only while the synchronised level disagrees with the
    // stable state; any agreement (bounce) restarts it from zero.
    always_comb begin
        cnt_next     = '0;
        state_next   = state_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (raw_act != state_reg) begin
            if (cnt_reg == CNT_LAST) begin
                state_next   = raw_act;
                press_next   = raw_act;
                release_next = ~raw_act;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            // Synchroniser starts at the released pin level, so a key held
            // through reset is seen as a fresh press.
            sync1_reg   <= KEY_ACTIVE_LOW;
            sync2_reg   <= KEY_ACTIVE_LOW;
            cnt_reg     <= '0;
            state_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            sync1_reg   <= key_pin;
            sync2_reg   <= sync1_reg;
            cnt_reg     <= cnt_next;
            state_reg   <= state_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    assign key_state   = state_reg;
    assign key_press   = press_reg;
    assign key_release = release_reg;

`ifdef LONG_PRESS_EN
    localparam int LONG_W = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX);
    localparam logic [LONG_W-1:0] LONG_ARM  = LONG_W'(LONG_MAX - 1);

    logic [LONG_W-1:0] hold_reg, hold_next;
    logic              long_reg, long_next;

    // Hold counter saturates at LONG_LAST, so the ARM->LAST step happens
    // only once per press and the pulse cannot repeat.
    always_comb begin
        hold_next = '0;
        long_next = 1'b0;
        if (state_reg) begin
            hold_next = (hold_reg == LONG_LAST) ? hold_reg : hold_reg + 1'b1;
            long_next = (hold_reg == LONG_ARM);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hold_reg <= '0;
            long_reg <= 1'b0;
        end else begin
            hold_reg <= hold_next;
            long_reg <= long_next;
        end
    end

    assign key_long = long_reg;
`else
    logic long_unused;
    assign long_unused = (LONG_MAX != 0);
    assign key_long    = 1'b0;
`endif

endmodule

// File: rtl/key_filter_multi.sv
// key_filter_multi
// Multi-channel push-button debouncer: N_KEYS fully independent channels,
// each synchronised, debounced in both directions, with press/release pulses
// and an optional long-press pulse.
// Ports:
//   sys_clk   system clock (single domain)
//   sys_rst   synchronous active-high reset
//   keys      key_filter_multi_if.slave: key_in in, key_state/key_press/
//             key_release/key_long out (N_KEYS bits each)
// Build option: LONG_PRESS_EN enables key_long; otherwise key_long is 0.
module key_filter_multi
    import key_filter_pkg::*;
#(
    parameter int N_KEYS         = 4,
    parameter int CNT_MAX        = KEY_CNT_MAX_20MS,
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int LONG_MAX       = KEY_LONG_MAX_1S
) (
    input logic              sys_clk,
    input logic              sys_rst,
    key_filter_multi_if.slave keys
);

    logic [N_KEYS-1:0] state_vec;
    logic [N_KEYS-1:0] press_vec;
    logic [N_KEYS-1:0] release_vec;
    logic [N_KEYS-1:0] long_vec;

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
            key_filter_chan #(
                .CNT_MAX        (CNT_MAX),
                .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
                .LONG_MAX       (LONG_MAX)
            ) u_chan (
                .sys_clk     (sys_clk),
                .sys_rst     (sys_rst),
                .key_pin     (keys.key_in[gi]),
                .key_state   (state_vec[gi]),
                .key_press   (press_vec[gi]),
                .key_release (release_vec[gi]),
                .key_long    (long_vec[gi])
            );
        end
    endgenerate

    assign keys.key_state   = state_vec;
    assign keys.key_press   = press_vec;
    assign keys.key_release = release_vec;
    assign keys.key_long    = long_vec;

endmodule

// File: tb/tb_key_filter_multi.sv
// tb_key_filter_multi
// Self-checking bench for key_filter_multi (N_KEYS=4, CNT_MAX=7, LONG_MAX=20,
// active-low pins). A cycle-by-cycle reference model derived from the
// "last CNT_MAX+1 synchronised samples all differ from the state" rule checks
// every output on every cycle; a vector table and hand-written sequences
// check timing and corner cases. Honours LONG_PRESS_EN like the RTL.
`timescale 1ns/1ps
module tb_key_filter_multi;

    localparam int N    = 4;
    localparam int CMAX = 7;
    localparam int LMAX = 20;
    localparam int HLEN = CMAX + 3;   // samples k-(CMAX+2) .. k

    logic sys_clk = 1'b0;
    logic sys_rst;

    key_filter_multi_if #(.N_KEYS(N)) kif ();

    key_filter_multi #(
        .N_KEYS         (N),
        .CNT_MAX        (CMAX),
        .KEY_ACTIVE_LOW (1'b1),
        .LONG_MAX       (LMAX)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .keys    (kif)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;
    logic [N-1:0] long_seen = '0;

    // ---------------- reference model ----------------
    // hist[k][i] = "pressed" value of the pin sampled i edges ago.
    bit hist [N][HLEN];
    bit m_state [N];
    bit m_press [N];
    bit m_rel   [N];
    bit m_long  [N];
    int m_age   [N];
    bit m_flip;

    always @(posedge sys_clk) begin
        for (int k = 0; k < N; k++) begin
            if (sys_rst) begin
                for (int i = 0; i < HLEN; i++) hist[k][i] = 1'b0;
                m_state[k] = 1'b0;
                m_press[k] = 1'b0;
                m_rel[k]   = 1'b0;
                m_long[k]  = 1'b0;
                m_age[k]   = 0;
            end else begin
                for (int i = HLEN - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = ~kif.key_in[k];
                // long press: cycles spent pressed, pulse on reaching LMAX
                m_long[k] = 1'b0;
                if (m_state[k]) begin
                    if (m_age[k] < LMAX) begin
                        m_age[k]++;
`ifdef LONG_PRESS_EN
                        if (m_age[k] == LMAX) m_long[k] = 1'b1;
`endif
                    end
                end else begin
                    m_age[k] = 0;
                end
                // flip when the CMAX+1 samples that reached the counter all disagree
                m_flip = 1'b1;
                for (int i = 2; i < HLEN; i++)
                    if (hist[k][i] == m_state[k]) m_flip = 1'b0;
                m_press[k] = m_flip && !m_state[k];
                m_rel[k]   = m_flip &&  m_state[k];
                if (m_flip) m_state[k] = !m_state[k];
            end
        end
    end

    logic [4*N-1:0] exp_v, act_v;
    always @(negedge sys_clk) begin
        if (check_en) begin
            for (int k = 0; k < N; k++) begin
                exp_v[3*N+k] = m_state[k];
                exp_v[2*N+k] = m_press[k];
                exp_v[N+k]   = m_rel[k];
                exp_v[k]     = m_long[k];
            end
            act_v = {kif.key_state, kif.key_press, kif.key_release, kif.key_long};
            long_seen = long_seen | kif.key_long;
            total++;
            if (act_v !== exp_v) begin
                bad++;
                if (bad <= 20)
                    $display("FAIL model t=%0t: state/press/rel/long got %h required %h",
                             $time, act_v, exp_v);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    // Watch one key's press (rel=0) or release (rel=1) for 'limit' cycles.
    task automatic watch(input int k, input bit rel, input int limit,
                         output int first, output int cnt);
        first = -1;
        cnt   = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge sys_clk);
            if ((rel ? kif.key_release[k] : kif.key_press[k]) === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic pulse_reset(input int n);
        sys_rst = 1'b1;
        repeat (n) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] pins;
        int         cycles;
        logic [3:0] state;
        logic [3:0] press;
        logic [3:0] rel;
    } vec_t;

    vec_t tbl [7];
    int   pc [N];
    int   rc [N];
    int   first, cnt, npulse, pn, ln, lc;
    logic [3:0] pv, pm, rm;
    int   run [N];
    logic [N-1:0] pins;

    initial begin
        tbl[0] = '{4'hE, 12, 4'b0001, 4'b0001, 4'b0000};  // key0 press
        tbl[1] = '{4'hF,  5, 4'b0001, 4'b0000, 4'b0000};  // short release glitch
        tbl[2] = '{4'hE,  3, 4'b0001, 4'b0000, 4'b0000};
        tbl[3] = '{4'h6, 12, 4'b1001, 4'b1000, 4'b0000};  // key3 press
        tbl[4] = '{4'hF, 12, 4'b0000, 4'b0000, 4'b1001};  // release both
        tbl[5] = '{4'h0,  7, 4'b0000, 4'b0000, 4'b0000};  // 7-cycle press glitch, all keys
        tbl[6] = '{4'hF, 10, 4'b0000, 4'b0000, 4'b0000};

        sys_rst    = 1'b1;
        kif.key_in = '1;
        repeat (3) @(negedge sys_clk);
        sys_rst  = 1'b0;
        check_en = 1'b1;
        check("reset key_state",   int'(kif.key_state),   0);
        check("reset key_press",   int'(kif.key_press),   0);
        check("reset key_release", int'(kif.key_release), 0);
        check("reset key_long",    int'(kif.key_long),    0);

        // ---- table-driven vectors ----
        for (int r = 0; r < 7; r++) begin
            kif.key_in = tbl[r].pins;
            for (int k = 0; k < N; k++) begin pc[k] = 0; rc[k] = 0; end
            for (int c = 0; c < tbl[r].cycles; c++) begin
                @(negedge sys_clk);
                for (int k = 0; k < N; k++) begin
                    if (kif.key_press[k] === 1'b1)   pc[k]++;
                    if (kif.key_release[k] === 1'b1) rc[k]++;
                end
            end
            for (int k = 0; k < N; k++) begin
                pm[k] = (pc[k] == 1);
                rm[k] = (rc[k] == 1);
            end
            check($sformatf("row%0d state", r),   int'(kif.key_state), int'(tbl[r].state));
            check($sformatf("row%0d press", r),   int'(pm),            int'(tbl[r].press));
            check($sformatf("row%0d release", r), int'(rm),            int'(tbl[r].rel));
        end

        // ---- 1: steady press on key0, latency 10 ----
        kif.key_in = '1;
        pulse_reset(1);
        kif.key_in = 4'hE;
        watch(0, 1'b0, 14, first, cnt);
        check("t1 press latency", first, 10);
        check("t1 press count", cnt, 1);
        check("t1 key_state", int'(kif.key_state), 4'b0001);

        // ---- 2: bounce on key1 then steady low ----
        npulse = 0;
        for (int b = 0; b < 6; b++) begin
            kif.key_in = 4'hC;
            repeat (5) begin
                @(negedge sys_clk);
                if (kif.key_press[1] === 1'b1) npulse++;
            end
            kif.key_in = 4'hE;
            repeat (2) begin
                @(negedge sys_clk);
                if (kif.key_press[1] === 1'b1) npulse++;
            end
        end
        check("t2 pulses during bounce", npulse, 0);
        kif.key_in = 4'hC;
        watch(1, 1'b0, 14, first, cnt);
        check("t2 press latency", first, 10);
        check("t2 press count", cnt, 1);

        // ---- 3: key2 release and 7-cycle release glitch ----
        kif.key_in = 4'h8;
        watch(2, 1'b0, 14, first, cnt);
        check("t3 key2 press latency", first, 10);
        kif.key_in = 4'hC;
        watch(2, 1'b1, 7, first, cnt);
        kif.key_in = 4'h8;
        watch(2, 1'b1, 12, first, npulse);
        check("t3 glitch releases", cnt + npulse, 0);
        check("t3 key2 still pressed", int'(kif.key_state[2]), 1);
        kif.key_in = 4'hC;
        watch(2, 1'b1, 14, first, cnt);
        check("t3 release latency", first, 10);
        check("t3 release count", cnt, 1);
        check("t3 key_state", int'(kif.key_state), 4'b0011);

        // ---- 4: reset mid-debounce with keys pressed ----
        kif.key_in = 4'h8;
        repeat (5) @(negedge sys_clk);
        pulse_reset(1);
        check("t4 state after reset", int'(kif.key_state), 0);
        check("t4 press after reset", int'(kif.key_press), 0);
        check("t4 release after reset", int'(kif.key_release), 0);
        watch(2, 1'b0, 14, first, cnt);
        check("t4 re-debounce latency", first, 10);
        check("t4 key_state", int'(kif.key_state), 4'b0111);

        // ---- 5: simultaneous press of keys 0 and 3 ----
        kif.key_in = 4'hF;
        repeat (14) @(negedge sys_clk);
        kif.key_in = 4'h6;
        npulse = 0;
        pv = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge sys_clk);
            if (kif.key_press !== 4'b0000) begin
                npulse++;
                pv = kif.key_press;
            end
        end
        check("t5 press cycles", npulse, 1);
        check("t5 press vector", int'(pv), 4'b1001);

`ifdef LONG_PRESS_EN
        // ---- 6: long press ----
        kif.key_in = 4'hF;
        repeat (14) @(negedge sys_clk);
        kif.key_in = 4'hE;
        pn = -1; ln = -1; lc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge sys_clk);
            if (kif.key_press[0] === 1'b1 && pn < 0) pn = i;
            if (kif.key_long[0] === 1'b1) begin
                lc++;
                if (ln < 0) ln = i;
            end
        end
        check("t6 long after press", ln - pn, 20);
        check("t6 long count", lc, 1);
        kif.key_in = 4'hF;
        repeat (14) @(negedge sys_clk);
        kif.key_in = 4'hE;
        watch(0, 1'b0, 10, first, cnt);
        repeat (4) @(negedge sys_clk);
        kif.key_in = 4'hF;
        lc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (kif.key_long[0] === 1'b1) lc++;
        end
        check("t6 short hold long count", lc, 0);
`endif

        // ---- randomized run against the model ----
        pins = '1;
        for (int k = 0; k < N; k++) run[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (run[k] == 0) begin
                    pins[k] = 1'($urandom_range(0, 1));
                    run[k]  = int'($urandom_range(1, 30));
                end
                run[k]--;
            end
            kif.key_in = pins;
            sys_rst    = ($urandom_range(0, 399) == 0);
            @(negedge sys_clk);
        end
        sys_rst = 1'b0;
        kif.key_in = '1;
        repeat (12) @(negedge sys_clk);

`ifndef LONG_PRESS_EN
        check("key_long never set", int'(long_seen), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
